disp_scan_4dig: RTL and testbench

//  Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.

---
 rtl/disp_scan_4dig_pkg.sv | 21 ++
 rtl/disp_scan_4dig_if.sv | 26 ++
 rtl/disp_scan_4dig_prescaler.sv | 27 ++
 rtl/disp_scan_4dig.sv | 94 +++++++++
 tb/tb_disp_scan_4dig.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/disp_scan_4dig_pkg.sv
// Shared constants, types and helpers for the 4-digit display scan controller.
package disp_scan_4dig_pkg;

  localparam int N_DIG = 4;
  localparam int IDX_W = 2;
  localparam logic [N_DIG-1:0] AN_OFF = 4'b1111;

  typedef logic [IDX_W-1:0] idx_t;

  // One complete display image: hex nibbles, decimal points and blank flags.
  typedef struct packed {
    logic [4*N_DIG-1:0] hexs;
    logic [N_DIG-1:0]   points;
    logic [N_DIG-1:0]   les;
  } disp_word_t;

  function automatic logic [N_DIG-1:0] an_sel(input idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/disp_scan_4dig_if.sv
// Data/strobe bundle between the display data source and the scan controller.
interface disp_scan_4dig_if;
  import disp_scan_4dig_pkg::*;

  logic                 load;
  logic [4*N_DIG-1:0]   hexs;
  logic [N_DIG-1:0]     points;
  logic [N_DIG-1:0]     LES;
  logic [3:0]           hex;
  logic                 point;
  logic                 LE;
  logic [N_DIG-1:0]     AN;
  logic                 frame;
  logic                 pending;

  modport master (
    output load, hexs, points, LES,
    input  hex, point, LE, AN, frame, pending
  );

  modport slave (
    input  load, hexs, points, LES,
    output hex, point, LE, AN, frame, pending
  );

endinterface

// File: rtl/disp_scan_4dig_prescaler.sv
// Free-running prescaler; tick is high for the one cycle the counter is all-ones.
module disp_scan_4dig_prescaler #(
  parameter int DIV_BITS = 17
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV_BITS-1:0] cnt_q;
  logic [DIV_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + DIV_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/disp_scan_4dig.sv
// 4-digit 7-segment scan controller with frame-synchronous double-buffered data.
module disp_scan_4dig
  import disp_scan_4dig_pkg::*;
#(
  parameter int DIV_BITS = 17
) (
  input  logic             clk,
  input  logic             rst,
  disp_scan_4dig_if.slave  bus
);

  logic       tick;
  logic       wrap;
  logic       apply;
  idx_t       idx_q, idx_d;
  disp_word_t shadow_q, shadow_d;
  disp_word_t active_q, active_d;
  disp_word_t src;
  logic       pending_q, pending_d;
  logic [3:0] hex_q, hex_d;
  logic [3:0] an_q, an_d;
  logic       point_q, point_d;
  logic       le_q, le_d;
  logic       frame_q, frame_d;

  disp_scan_4dig_prescaler #(
    .DIV_BITS(DIV_BITS)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    wrap  = tick && (idx_q == idx_t'(N_DIG - 1));
    apply = wrap && pending_q;
    // Digit 0 of a new frame must already show the freshly applied data.
    src   = apply ? shadow_q : active_q;

    idx_d     = tick ? idx_q + idx_t'(1) : idx_q;
    active_d  = apply ? shadow_q : active_q;
    shadow_d  = shadow_q;
    pending_d = apply ? 1'b0 : pending_q;
    // A load on the wrap edge refills the shadow after its old value was applied.
    if (bus.load) begin
      shadow_d  = '{hexs: bus.hexs, points: bus.points, les: bus.LES};
      pending_d = 1'b1;
    end

    an_d    = an_q;
    hex_d   = hex_q;
    point_d = point_q;
    le_d    = le_q;
    frame_d = wrap;
    if (tick) begin
      an_d    = an_sel(idx_d);
      hex_d   = src.hexs[{idx_d, 2'b00} +: 4];
      point_d = src.points[idx_d];
      le_d    = src.les[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      an_q      <= AN_OFF;
      hex_q     <= '0;
      point_q   <= 1'b0;
      le_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      hex_q     <= hex_d;
      point_q   <= point_d;
      le_q      <= le_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.AN      = an_q;
  assign bus.hex     = hex_q;
  assign bus.point   = point_q;
  assign bus.LE      = le_q;
  assign bus.frame   = frame_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_disp_scan_4dig.sv
// Directed scoreboard bench for disp_scan_4dig with a 4-cycle scan tick.
module tb_disp_scan_4dig;
  import disp_scan_4dig_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  disp_scan_4dig_if bus();

  disp_scan_4dig #(
    .DIV_BITS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [11:0] vec;
  } exp_t;

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [3:0] last_an     = 4'b1111;

  task automatic drive(input logic ld, input logic [15:0] hx, input logic [3:0] pt,
                       input logic [3:0] les);
    bus.load   = ld;
    bus.hexs   = hx;
    bus.points = pt;
    bus.LES    = les;
  endtask

  task automatic expect_v(input string tag, input logic [3:0] an, input logic [3:0] hx,
                          input logic pt, input logic le, input logic fr, input logic pd);
    exp_t e;
    e.tag = tag;
    e.vec = {an, hx, pt, le, fr, pd};
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t        e;
    logic [11:0] obs;
    obs = {bus.AN, bus.hex, bus.point, bus.LE, bus.frame, bus.pending};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed %b with no expected entry", obs);
    end else begin
      e = sb.pop_front();
      $display("[%0t] %s AN=%b hex=%h point=%b LE=%b frame=%b pending=%b", $time, e.tag,
               bus.AN, bus.hex, bus.point, bus.LE, bus.frame, bus.pending);
      assert (obs === e.vec) else begin
        miscompares++;
        $error("FAIL %s: observed AN=%b hex=%h point=%b LE=%b frame=%b pending=%b, expected AN=%b hex=%h point=%b LE=%b frame=%b pending=%b",
               e.tag, obs[11:8], obs[7:4], obs[3], obs[2], obs[1], obs[0],
               e.vec[11:8], e.vec[7:4], e.vec[3], e.vec[2], e.vec[1], e.vec[0]);
      end
    end
    last_an = bus.AN;
  endtask

  // Wait (bounded) for the next scan step, seen as a change on AN, then compare.
  task automatic tick_check(input string tag, input logic [3:0] an, input logic [3:0] hx,
                            input logic pt, input logic le, input logic fr, input logic pd);
    int   n;
    exp_t e;
    expect_v(tag, an, hx, pt, le, fr, pd);
    n = 0;
    while (bus.AN === last_an && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (bus.AN === last_an) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_timeout: observed AN=%b unchanged, expected AN=%b", tag, bus.AN, an);
      e = sb.pop_front();
    end else begin
      sample();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b1, 16'hFFFF, 4'hF, 4'hF);
    repeat (3) @(negedge clk);
    expect_v("reset", 4'b1111, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    sample();

    rst = 1'b0;
    drive(1'b1, 16'h1234, 4'b0101, 4'b0000);
    @(negedge clk);
    drive(1'b0, 16'h0000, 4'h0, 4'h0);
    expect_v("load_pending", 4'b1111, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    sample();

    tick_check("s2_idx1_old", 4'b1101, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_check("s2_idx2_old", 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_check("s2_idx3_old", 4'b0111, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_check("s2_wrap_d0",  4'b1110, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0);
    tick_check("s2_d1",       4'b1101, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("s2_d2",       4'b1011, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_check("s2_d3",       4'b0111, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("s2_wrap2_d0", 4'b1110, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0);
    tick_check("s3_d1",       4'b1101, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 16'hABCD, 4'b0000, 4'b0000);
    @(negedge clk);
    drive(1'b0, 16'h0000, 4'h0, 4'h0);
    expect_v("s3_pending", 4'b1101, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
    sample();
    tick_check("s3_d2_old",   4'b1011, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
    tick_check("s3_d3_old",   4'b0111, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_check("s3_wrap_d0",  4'b1110, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    expect_v("s3_frame_low", 4'b1110, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    tick_check("s3_d1_new",   4'b1101, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("s3_d2_new",   4'b1011, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("s3_d3_new",   4'b0111, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 16'h1111, 4'b0000, 4'b0000);
    @(negedge clk);
    drive(1'b1, 16'h2222, 4'b0000, 4'b1000);
    @(negedge clk);
    drive(1'b0, 16'h0000, 4'h0, 4'h0);
    tick_check("s4_wrap_d0",  4'b1110, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
    tick_check("s4_d1",       4'b1101, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("s4_d2",       4'b1011, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("s4_d3_blank", 4'b0111, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 16'h0000, 4'b0000, 4'b0000);
    @(negedge clk);
    drive(1'b0, 16'h0000, 4'h0, 4'h0);
    tick_check("s5_zero_d0",  4'b1110, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick_check("s5_zero_d1",  4'b1101, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h5555, 4'b0000, 4'b0000);
    @(negedge clk);
    drive(1'b0, 16'h0000, 4'h0, 4'h0);
    tick_check("s5_zero_d2",  4'b1011, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_check("s5_zero_d3",  4'b0111, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    drive(1'b1, 16'h7777, 4'b0000, 4'b0000);
    @(negedge clk);
    drive(1'b0, 16'h0000, 4'h0, 4'h0);
    tick_check("s5_coinc_d0", 4'b1110, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1);
    tick_check("s5_5_d1",     4'b1101, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_check("s5_5_d2",     4'b1011, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_check("s5_5_d3",     4'b0111, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_check("s5_7_d0",     4'b1110, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick_check("s5_7_d1",     4'b1101, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 16'h9999, 4'b1111, 4'b0000);
    @(negedge clk);
    drive(1'b0, 16'h0000, 4'h0, 4'h0);
    tick_check("s6_d2",       4'b1011, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    expect_v("s6_mid_reset", 4'b1111, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    rst = 1'b0;
    tick_check("s6_r_d1",     4'b1101, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("s6_r_d2",     4'b1011, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("s6_r_d3",     4'b0111, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_check("s6_r_wrap",   4'b1110, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
